cv32e40x_mpu_obi: RTL



---
 rtl/cv32e40x_mpu_obi_pkg.sv | 27 ++
 rtl/cv32e40x_pma.sv | 48 ++++
 rtl/cv32e40x_mpu_obi.sv | 105 ++++++++++
 3 files changed

// File: rtl/cv32e40x_mpu_obi_pkg.sv
// cv32e40x_mpu_obi_pkg: shared types for the OBI MPU front-end and its PMA checker
// Holds the FSM state and response status enums, the PMA region record and
// the fallback region configurations used when no region matches.
package cv32e40x_mpu_obi_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} mpu_state_e;

    typedef enum logic [1:0] {MPU_OK, MPU_RE_FAULT, MPU_WR_FAULT} mpu_status_e;

    // Region covers addr_lo <= addr < addr_hi
    typedef struct packed {
        logic [31:0] addr_lo;
        logic [31:0] addr_hi;
        logic        main;
        logic        bufferable;
        logic        cacheable;
        logic        atomic;
    } pma_cfg_t;

    localparam pma_cfg_t PMA_R_DEFAULT = '{addr_lo: 32'h0, addr_hi: 32'h0, main: 1'b0,
                                           bufferable: 1'b0, cacheable: 1'b0, atomic: 1'b0};

    // Attributes applied when no regions are configured and inside the debug window
    localparam pma_cfg_t PMA_R_NO_PMA = '{addr_lo: 32'h0, addr_hi: 32'h0, main: 1'b1,
                                          bufferable: 1'b0, cacheable: 1'b0, atomic: 1'b1};

endpackage

// File: rtl/cv32e40x_pma.sv
// cv32e40x_pma: physical memory attribute lookup and access check
// Ports: addr/instr_fetch/dbg/atomic/misaligned/modified describe the access,
// err flags an illegal access, memtype is {cacheable, bufferable} of the hit.
// With regions configured, an address that hits no region is inaccessible;
// debug accesses inside the DM window always use main-memory attributes.
module cv32e40x_pma import cv32e40x_mpu_obi_pkg::*; #(
    parameter int          PMA_NUM_REGIONS = 0,
    parameter pma_cfg_t    PMA_CFG[PMA_NUM_REGIONS-1:0] = '{default: PMA_R_DEFAULT},
    parameter logic [31:0] DM_REGION_START = 32'hF0000000,
    parameter logic [31:0] DM_REGION_END   = 32'hF0003FFF
) (
    input  logic [31:0] addr,
    input  logic        instr_fetch,
    input  logic        dbg,
    input  logic        atomic,
    input  logic        misaligned,
    input  logic        modified,
    output logic        err,
    output logic [1:0]  memtype
);
    pma_cfg_t cfg;
    logic     miss;

    always_comb begin
        cfg  = PMA_R_NO_PMA;
        miss = 1'b0;
        if (PMA_NUM_REGIONS > 0) begin
            cfg  = PMA_R_DEFAULT;
            miss = 1'b1;
            // Walk downwards so the lowest-numbered matching region wins
            for (int i = PMA_NUM_REGIONS - 1; i >= 0; i--) begin
                if (addr >= PMA_CFG[i].addr_lo && addr < PMA_CFG[i].addr_hi) begin
                    cfg  = PMA_CFG[i];
                    miss = 1'b0;
                end
            end
        end
        if (dbg && addr >= DM_REGION_START && addr <= DM_REGION_END) begin
            cfg  = PMA_R_NO_PMA;
            miss = 1'b0;
        end
    end

    assign err = miss || ((instr_fetch || misaligned || modified) && !cfg.main) ||
                 (atomic && !cfg.atomic);
    assign memtype = {cfg.cacheable, cfg.bufferable};

endmodule

// File: rtl/cv32e40x_mpu_obi.sv
// cv32e40x_mpu_obi: PMA-checking OBI front-end with in-order fault responses
// Ports: core_trans_* request from IF/LSU, bus_trans_* forwarded request,
// bus_resp_valid_i / core_resp_* response path, core_mpu_err_o live PMA error,
// outstanding_o in-flight count, err_cnt_o fault counter.
// Build option: define CV32E40X_MPU_ERR_CNT_EN for a saturating fault counter;
// otherwise err_cnt_o is constant zero.
module cv32e40x_mpu_obi import cv32e40x_mpu_obi_pkg::*; #(
    parameter int          IF_STAGE        = 1,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          PMA_NUM_REGIONS = 0,
    parameter pma_cfg_t    PMA_CFG[PMA_NUM_REGIONS-1:0] = '{default: PMA_R_DEFAULT},
    parameter logic [31:0] DM_REGION_START = 32'hF0000000,
    parameter logic [31:0] DM_REGION_END   = 32'hF0003FFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_trans_valid_i,
    output logic        core_trans_ready_o,
    input  logic [31:0] core_trans_addr_i,
    input  logic        core_trans_we_i,
    input  logic        core_trans_dbg_i,
    input  logic        core_trans_atomic_i,
    input  logic        core_trans_misaligned_i,
    input  logic        core_trans_modified_i,
    output logic        bus_trans_valid_o,
    input  logic        bus_trans_ready_i,
    output logic [31:0] bus_trans_addr_o,
    output logic        bus_trans_we_o,
    output logic [1:0]  bus_trans_memtype_o,
    input  logic        bus_resp_valid_i,
    output logic        core_resp_valid_o,
    output mpu_status_e core_resp_status_o,
    output logic        core_mpu_err_o,
    output logic [2:0]  outstanding_o,
    output logic [15:0] err_cnt_o
);
    localparam int CW = 3;

    mpu_state_e    state_q;
    logic [CW-1:0] outst_q, outst_n;
    logic          we_q, we, pma_err, room, idle, bus_hs, resp_dec, fault_take;

    cv32e40x_pma #(
        .PMA_NUM_REGIONS (PMA_NUM_REGIONS),
        .PMA_CFG         (PMA_CFG),
        .DM_REGION_START (DM_REGION_START),
        .DM_REGION_END   (DM_REGION_END)
    ) u_pma (
        .addr        (core_trans_addr_i),
        .instr_fetch (IF_STAGE != 0),
        .dbg         (core_trans_dbg_i),
        .atomic      (core_trans_atomic_i),
        .misaligned  (core_trans_misaligned_i),
        .modified    (core_trans_modified_i),
        .err         (pma_err),
        .memtype     (bus_trans_memtype_o)
    );

    assign we   = (IF_STAGE != 0) ? 1'b0 : core_trans_we_i;
    assign room = outst_q < CW'(MAX_OUTSTANDING);
    assign idle = rst_n && state_q == IDLE && room;

    assign core_mpu_err_o     = pma_err;
    assign bus_trans_valid_o  = idle && core_trans_valid_i && !pma_err;
    // A faulting request is consumed without waiting for the bus
    assign core_trans_ready_o = idle && (pma_err || bus_trans_ready_i);
    assign bus_trans_addr_o   = core_trans_addr_i;
    assign bus_trans_we_o     = we;

    assign bus_hs     = bus_trans_valid_o && bus_trans_ready_i;
    // A stray response with nothing in flight must not wrap the counter
    assign resp_dec   = bus_resp_valid_i && outst_q != '0;
    assign outst_n    = outst_q + CW'(bus_hs) - CW'(resp_dec);
    assign fault_take = core_trans_valid_i && core_trans_ready_o && pma_err;

    assign core_resp_valid_o  = rst_n && (state_q == RESP || bus_resp_valid_i);
    assign core_resp_status_o = state_q != RESP ? MPU_OK : we_q ? MPU_WR_FAULT : MPU_RE_FAULT;
    assign outstanding_o      = outst_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            outst_q <= '0;
            we_q    <= 1'b0;
        end else begin
            outst_q <= outst_n;
            state_q <= state_q == RESP ? IDLE :
                       (state_q == WAIT || fault_take) ? (outst_n == '0 ? RESP : WAIT) : IDLE;
            if (fault_take) we_q <= we;
        end
    end

`ifdef CV32E40X_MPU_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) err_cnt_o <= '0;
        else if (state_q == RESP && err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
    end
`else
    assign err_cnt_o = '0;
`endif

    a_no_stray_resp: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus_resp_valid_i && outst_q == '0));

endmodule
